sdram_port_arb: RTL and testbench

SDRAM_PORT_ARB -- requirements
Module: sdram_port_arb

---
 rtl/sdram_arb_pkg.sv | 27 ++
 rtl/rr_arb4.sv | 20 ++
 rtl/sdram_port_arb.sv | 162 ++++++++++++++++
 tb/tb_sdram_port_arb.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared state encodings, port indices and defaults for the SDRAM port arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } arb_state_t;

  localparam logic [1:0] WR0 = 2'd0;
  localparam logic [1:0] WR1 = 2'd1;
  localparam logic [1:0] RD0 = 2'd2;
  localparam logic [1:0] RD1 = 2'd3;

  localparam int TIMEOUT_CYC_DEFAULT = 1024;

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin picker; the search starts at last+1 and wraps.
module rr_arb4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [3:0] grant
);

  logic [1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest requester wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int i = 4; i >= 1; i--) begin
      idx = last + i[1:0];
      if (req[idx]) grant = 4'b0001 << idx;
    end
  end

endmodule

// File: rtl/sdram_port_arb.sv
// Round-robin arbiter for two write and two read requesters onto one SDRAM master port.
// Enable rises two cycles after a sampled request; each operation ends in a watchdog-bounded done and a 2-cycle gap.
module sdram_port_arb
  import sdram_arb_pkg::*;
#(
  parameter int SDRAM_ADDRS_WIDE = 21,
  parameter int SDRAM_DATA_WIDE  = 32,
  parameter int TIMEOUT_CYC      = TIMEOUT_CYC_DEFAULT
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_sdram_init_done,
  input  logic [3:0]                    i_req,
  input  logic [4*SDRAM_ADDRS_WIDE-1:0] i_addrs,
  input  logic [31:0]                   i_lengths,
  input  logic [15:0]                   i_dqm,
  input  logic [2*SDRAM_DATA_WIDE-1:0]  i_wr_data,
  output logic [1:0]                    o_wr_data_req,
  output logic [3:0]                    o_grant,
  output logic [3:0]                    o_done,
  output logic [3:0]                    o_nack,
  output logic                          o_timeout,
  output logic                          o_m_wr_en,
  output logic                          o_m_rd_en,
  output logic [SDRAM_ADDRS_WIDE-1:0]   o_m_addrs,
  output logic [7:0]                    o_m_lengths,
  output logic [3:0]                    o_m_dqm,
  output logic [SDRAM_DATA_WIDE-1:0]    o_m_wr_data,
  input  logic                          i_m_wr_data_req,
  input  logic                          i_m_rw_over,
  input  logic                          i_m_rd_wr_done,
  input  logic                          i_m_rw_nack
);

  localparam int AW    = SDRAM_ADDRS_WIDE;
  localparam int DW    = SDRAM_DATA_WIDE;
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  arb_state_t          state, state_n;
  logic [1:0]          last_owner, last_n, owner, win;
  logic [3:0]          rr_grant, grant_n, done_n, nack_n;
  logic                timeout_n, wr_en_n, rd_en_n, sticky_nack, sticky_n, gap_cnt, gap_cnt_n;
  logic [AW-1:0]       addrs_n;
  logic [7:0]          len_n;
  logic [3:0]          dqm_n;
  logic [CNT_W-1:0]    wd_cnt, wd_cnt_n;

  rr_arb4 u_rr (.req(i_req), .last(last_owner), .grant(rr_grant));

  assign owner = onehot_to_idx(o_grant);
  assign win   = onehot_to_idx(rr_grant);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      last_owner  <= RD1;
      o_grant     <= '0;
      o_done      <= '0;
      o_nack      <= '0;
      o_timeout   <= 1'b0;
      o_m_wr_en   <= 1'b0;
      o_m_rd_en   <= 1'b0;
      o_m_addrs   <= '0;
      o_m_lengths <= '0;
      o_m_dqm     <= '0;
      wd_cnt      <= '0;
      sticky_nack <= 1'b0;
      gap_cnt     <= 1'b0;
    end else begin
      state       <= state_n;
      last_owner  <= last_n;
      o_grant     <= grant_n;
      o_done      <= done_n;
      o_nack      <= nack_n;
      o_timeout   <= timeout_n;
      o_m_wr_en   <= wr_en_n;
      o_m_rd_en   <= rd_en_n;
      o_m_addrs   <= addrs_n;
      o_m_lengths <= len_n;
      o_m_dqm     <= dqm_n;
      wd_cnt      <= wd_cnt_n;
      sticky_nack <= sticky_n;
      gap_cnt     <= gap_cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    last_n    = last_owner;
    grant_n   = o_grant;
    done_n    = '0;
    nack_n    = '0;
    timeout_n = o_timeout;
    wr_en_n   = o_m_wr_en;
    rd_en_n   = o_m_rd_en;
    addrs_n   = o_m_addrs;
    len_n     = o_m_lengths;
    dqm_n     = o_m_dqm;
    wd_cnt_n  = wd_cnt;
    sticky_n  = sticky_nack;
    gap_cnt_n = gap_cnt;
    // Losing SDRAM init aborts silently; the owner is not marked served.
    if (!i_sdram_init_done) begin
      state_n   = IDLE;
      grant_n   = '0;
      wr_en_n   = 1'b0;
      rd_en_n   = 1'b0;
      wd_cnt_n  = '0;
      sticky_n  = 1'b0;
      gap_cnt_n = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_m_rw_over && (i_req != 4'b0000)) begin
            grant_n  = rr_grant;
            addrs_n  = i_addrs[win*AW +: AW];
            len_n    = i_lengths[win*8 +: 8];
            dqm_n    = i_dqm[win*4 +: 4];
            wd_cnt_n = '0;
            sticky_n = 1'b0;
            state_n  = ISSUE;
          end
        end
        ISSUE: begin
          wr_en_n = (owner == WR0) || (owner == WR1);
          rd_en_n = (owner == RD0) || (owner == RD1);
          state_n = WAIT_DONE;
        end
        WAIT_DONE: begin
          // A nack seen on the completing cycle still counts.
          sticky_n = sticky_nack | i_m_rw_nack;
          if (i_m_rd_wr_done || (wd_cnt == CNT_W'(TIMEOUT_CYC - 1))) begin
            wr_en_n   = 1'b0;
            rd_en_n   = 1'b0;
            done_n    = o_grant;
            nack_n    = (sticky_n || !i_m_rd_wr_done) ? o_grant : 4'b0000;
            timeout_n = o_timeout | !i_m_rd_wr_done;
            last_n    = owner;
            grant_n   = '0;
            gap_cnt_n = 1'b0;
            state_n   = GAP;
          end else begin
            wd_cnt_n = wd_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt) state_n = IDLE;
          else gap_cnt_n = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    o_m_wr_data = '0;
    if (o_grant[WR0])      o_m_wr_data = i_wr_data[DW-1:0];
    else if (o_grant[WR1]) o_m_wr_data = i_wr_data[2*DW-1:DW];
  end

  assign o_wr_data_req = {o_grant[WR1], o_grant[WR0]} & {2{i_m_wr_data_req}};

endmodule

// File: tb/tb_sdram_port_arb.sv
// Bench for sdram_port_arb: directed scenarios plus randomized traffic against a cycle model.
module tb_sdram_port_arb;

  localparam int AW = 21;
  localparam int DW = 32;
  localparam int TO = 16;

  logic              i_clk;
  logic              i_rst;
  logic              i_sdram_init_done;
  logic [3:0]        i_req;
  logic [4*AW-1:0]   i_addrs;
  logic [31:0]       i_lengths;
  logic [15:0]       i_dqm;
  logic [2*DW-1:0]   i_wr_data;
  logic [1:0]        o_wr_data_req;
  logic [3:0]        o_grant, o_done, o_nack;
  logic              o_timeout, o_m_wr_en, o_m_rd_en;
  logic [AW-1:0]     o_m_addrs;
  logic [7:0]        o_m_lengths;
  logic [3:0]        o_m_dqm;
  logic [DW-1:0]     o_m_wr_data;
  logic              i_m_wr_data_req, i_m_rw_over, i_m_rd_wr_done, i_m_rw_nack;

  sdram_port_arb #(.SDRAM_ADDRS_WIDE(AW), .SDRAM_DATA_WIDE(DW), .TIMEOUT_CYC(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sdram_init_done(i_sdram_init_done),
    .i_req(i_req), .i_addrs(i_addrs), .i_lengths(i_lengths), .i_dqm(i_dqm),
    .i_wr_data(i_wr_data), .o_wr_data_req(o_wr_data_req), .o_grant(o_grant),
    .o_done(o_done), .o_nack(o_nack), .o_timeout(o_timeout),
    .o_m_wr_en(o_m_wr_en), .o_m_rd_en(o_m_rd_en), .o_m_addrs(o_m_addrs),
    .o_m_lengths(o_m_lengths), .o_m_dqm(o_m_dqm), .o_m_wr_data(o_m_wr_data),
    .i_m_wr_data_req(i_m_wr_data_req), .i_m_rw_over(i_m_rw_over),
    .i_m_rd_wr_done(i_m_rd_wr_done), .i_m_rw_nack(i_m_rw_nack)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_cnt[4] = '{default: 0};
  int nack_cnt[4] = '{default: 0};
  int strb0   = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (operation-level view) ----------------
  int m_owner, m_last, m_age, m_gap;
  bit m_sticky;
  logic [3:0]    e_grant, e_done, e_nack;
  logic          e_timeout, e_wr, e_rd;
  logic [AW-1:0] e_addrs;
  logic [7:0]    e_len;
  logic [3:0]    e_dqm;

  function automatic int rr_pick(input logic [3:0] req, input int last);
    for (int i = 1; i <= 4; i++) begin
      if (req[(last + i) % 4]) return (last + i) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = 3; m_age = 0; m_gap = 0; m_sticky = 0;
    e_grant = 0; e_done = 0; e_nack = 0; e_timeout = 0; e_wr = 0; e_rd = 0;
    e_addrs = 0; e_len = 0; e_dqm = 0;
  endtask

  task automatic model_step();
    int w;
    e_done = 0;
    e_nack = 0;
    if (!i_sdram_init_done) begin
      m_owner = -1; m_gap = 0; e_grant = 0; e_wr = 0; e_rd = 0;
    end else if (m_gap > 0) begin
      m_gap--;
    end else if (m_owner < 0) begin
      if (i_m_rw_over && i_req != 0) begin
        w = rr_pick(i_req, m_last);
        m_owner = w; m_age = 0; m_sticky = 0;
        e_grant = 4'(1 << w);
        e_addrs = i_addrs[w*AW +: AW];
        e_len   = i_lengths[w*8 +: 8];
        e_dqm   = i_dqm[w*4 +: 4];
      end
    end else if (m_age == 0) begin
      m_age = 1;
      e_wr = (m_owner < 2);
      e_rd = (m_owner >= 2);
    end else begin
      m_sticky = m_sticky | i_m_rw_nack;
      if (i_m_rd_wr_done || m_age == TO) begin
        e_done = 4'(1 << m_owner);
        e_nack = (m_sticky || !i_m_rd_wr_done) ? e_done : 4'b0000;
        if (!i_m_rd_wr_done) e_timeout = 1;
        m_last = m_owner; m_owner = -1; m_gap = 2;
        e_grant = 0; e_wr = 0; e_rd = 0;
      end else begin
        m_age++;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge i_clk or posedge i_rst);
      if (i_rst) model_reset();
      else model_step();
    end
  end

  // Compare every cycle, on the falling edge.
  initial begin
    logic [DW-1:0] exp_wd;
    forever begin
      @(negedge i_clk);
      exp_wd = e_grant[0] ? i_wr_data[DW-1:0] : (e_grant[1] ? i_wr_data[2*DW-1:DW] : '0);
      check("grant", o_grant, e_grant);
      check("done", o_done, e_done);
      check("nack", o_nack, e_nack);
      check("timeout", o_timeout, e_timeout);
      check("wr_en", o_m_wr_en, e_wr);
      check("rd_en", o_m_rd_en, e_rd);
      check("addrs", o_m_addrs, e_addrs);
      check("lengths", o_m_lengths, e_len);
      check("dqm", o_m_dqm, e_dqm);
      check("wr_data", o_m_wr_data, exp_wd);
      check("wr_data_req", o_wr_data_req, e_grant[1:0] & {2{i_m_wr_data_req}});
      for (int k = 0; k < 4; k++) begin
        if (o_done[k]) done_cnt[k]++;
        if (o_done[k] && o_nack[k]) nack_cnt[k]++;
      end
      if (o_wr_data_req[0]) strb0++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic do_reset();
    i_rst = 1; i_req = 0; i_m_rd_wr_done = 0; i_m_rw_nack = 0; i_m_wr_data_req = 0;
    i_m_rw_over = 1; i_sdram_init_done = 1;
    tick(); tick();
    i_rst = 0;
    tick();
  endtask

  task automatic wait_en(output int port, output int rise_cyc, output bit was_wr);
    int w = 0;
    while (!(o_m_wr_en || o_m_rd_en) && w < 40) begin
      @(negedge i_clk);
      w++;
    end
    check("enable_wait_bound", w < 40, 1);
    port = -1;
    for (int k = 0; k < 4; k++) if (o_grant[k]) port = k;
    rise_cyc = cyc;
    was_wr = o_m_wr_en;
  endtask

  task automatic drive_op(input int ncyc, input int nstrb, input bit nk);
    for (int i = 1; i <= ncyc; i++) begin
      tick();
      i_m_wr_data_req = (i <= nstrb);
      i_m_rw_nack     = nk && (i == 2);
      i_m_rd_wr_done  = (i == ncyc);
    end
    tick();
    i_m_wr_data_req = 0; i_m_rw_nack = 0; i_m_rd_wr_done = 0;
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    int p, rc, c0, s0, d0, n0, w, dsum;
    bit wr;
    i_addrs = '0; i_lengths = '0; i_dqm = '0; i_wr_data = '0;
    i_rst = 1; i_req = 0; i_sdram_init_done = 1; i_m_rw_over = 1;
    i_m_rd_wr_done = 0; i_m_rw_nack = 0; i_m_wr_data_req = 0;
    tick();
    check("rst_grant", o_grant, 0);
    check("rst_en", {o_m_wr_en, o_m_rd_en}, 0);
    check("rst_timeout", o_timeout, 0);
    check("rst_addrs", o_m_addrs, 0);

    // Single write on port 0.
    do_reset();
    i_addrs[0 +: AW] = 21'h00100; i_lengths = 32'h0000_0007; i_dqm = 16'h000F;
    i_wr_data = {32'hBBBB_CCCC, 32'hA5A5_5A5A};
    s0 = strb0; d0 = done_cnt[0]; n0 = nack_cnt[0];
    i_req = 4'b0001; c0 = cyc;
    wait_en(p, rc, wr);
    check("wr0_rise_latency", rc - c0, 2);
    check("wr0_port", p, 0);
    check("wr0_is_write", wr, 1);
    check("wr0_addr", o_m_addrs, 64'h100);
    check("wr0_len", o_m_lengths, 7);
    check("wr0_data", o_m_wr_data, 32'hA5A5_5A5A);
    drive_op(12, 8, 0);
    i_req = 0;
    tick();
    check("wr0_strobes", strb0 - s0, 8);
    check("wr0_done_once", done_cnt[0] - d0, 1);
    check("wr0_nack", nack_cnt[0] - n0, 0);

    // All four requesting: rotation and read/write enable choice.
    do_reset();
    i_req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_en(p, rc, wr);
      check("rr_order", p, exp_order[k]);
      check("rr_rw_select", wr, (p < 2));
      drive_op(3, 0, 0);
    end
    i_req = 0;

    // Master nack during port 2 read.
    do_reset();
    d0 = done_cnt[2]; n0 = nack_cnt[2];
    i_req = 4'b0100;
    wait_en(p, rc, wr);
    check("nack_port", p, 2);
    check("nack_is_read", wr, 0);
    drive_op(6, 0, 1);
    i_req = 0;
    tick();
    check("nack_done", done_cnt[2] - d0, 1);
    check("nack_flag", nack_cnt[2] - n0, 1);
    check("nack_no_timeout", o_timeout, 0);

    // Watchdog: the master never completes.
    do_reset();
    i_req = 4'b0010;
    wait_en(p, rc, wr);
    w = 0;
    while (!o_done[1] && w < 40) begin
      @(negedge i_clk);
      w++;
    end
    check("to_done_bound", w < 40, 1);
    check("to_latency", cyc - rc, 16);
    check("to_nack", o_nack[1], 1);
    check("to_flag", o_timeout, 1);
    tick();
    i_req = 4'b1000;
    wait_en(p, rc, wr);
    check("to_next_port", p, 3);
    check("to_sticky", o_timeout, 1);
    drive_op(3, 0, 0);
    i_req = 0;

    // Init lost mid-operation.
    do_reset();
    i_req = 4'b0011;
    wait_en(p, rc, wr);
    tick(); tick();
    dsum = done_cnt[0] + done_cnt[1];
    i_sdram_init_done = 0;
    tick();
    check("init_drop_en", {o_m_wr_en, o_m_rd_en}, 0);
    check("init_drop_grant", o_grant, 0);
    i_sdram_init_done = 1;
    wait_en(p, rc, wr);
    check("init_drop_no_done", done_cnt[0] + done_cnt[1], dsum);
    check("init_drop_next_port", p, 0);
    drive_op(3, 0, 0);
    i_req = 0;

    // Reset mid-operation.
    do_reset();
    i_req = 4'b0011;
    wait_en(p, rc, wr);
    drive_op(3, 0, 0);
    wait_en(p, rc, wr);
    check("rst_mid_port_before", p, 1);
    tick();
    dsum = done_cnt[0] + done_cnt[1];
    i_rst = 1;
    #1;
    check("rst_mid_async_en", {o_m_wr_en, o_m_rd_en}, 0);
    check("rst_mid_async_grant", o_grant, 0);
    tick();
    i_rst = 0;
    wait_en(p, rc, wr);
    check("rst_mid_no_done", done_cnt[0] + done_cnt[1], dsum);
    check("rst_mid_next_port", p, 0);
    drive_op(3, 0, 0);
    i_req = 0;

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(7) == 0) i_req[k] = ~i_req[k];
        i_addrs[k*AW +: AW] = AW'($urandom);
      end
      i_lengths         = $urandom;
      i_dqm             = 16'($urandom);
      i_wr_data         = {$urandom, $urandom};
      i_m_wr_data_req   = 1'($urandom_range(1));
      i_m_rw_over       = ($urandom_range(9) != 0);
      i_m_rd_wr_done    = ($urandom_range(9) == 0);
      i_m_rw_nack       = ($urandom_range(19) == 0);
      i_sdram_init_done = ($urandom_range(99) != 0);
      i_rst             = ($urandom_range(999) == 0);
    end
    i_rst = 0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
